// File: rtl/tone_pkg.sv
// Shared constants, types and helpers for the multi-channel square-wave tone generator.
package tone_pkg;

    localparam int TONE_BASE_W = 10;

    // Entry [0] is "do"; entries are base half-periods in tick units.
    localparam logic [11:0][TONE_BASE_W-1:0] TONE_TABLE = {
        10'h18B, 10'h1A3, 10'h1BB, 10'h1D6, 10'h1F2, 10'h20F,
        10'h22F, 10'h250, 10'h273, 10'h299, 10'h2C0, 10'h2EA
    };

    localparam logic [3:0] TONE_REST_MIN = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        REST = 2'd2
    } ch_state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: note FSM, one-deep pending slot, half-period counter and duration counter.
module tone_channel
    import tone_pkg::*;
#(
    parameter int PRESCALE_W = 10,
    parameter int OCT_W      = 2,
    parameter int DUR_W      = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             dur_tick,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_tone,
    input  logic [OCT_W-1:0] note_octave,
    input  logic [DUR_W-1:0] note_dur,
    output logic             wave_out,
    output logic             busy,
    output logic             done
);

    ch_state_t            state_q, state_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [DUR_W-1:0]      dur_q, dur_d;
    logic                  wave_q, wave_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [3:0]            pend_tone_q, pend_tone_d;
    logic [OCT_W-1:0]      pend_oct_q, pend_oct_d;
    logic [DUR_W-1:0]      pend_dur_q, pend_dur_d;

    logic                  accept_s, active_s, expire_s, boundary_s, sustain_s;
    logic                  load_s, load_pend_s, keep_wave_s;
    logic [3:0]            ld_tone_s;
    logic [OCT_W-1:0]      ld_oct_s;
    logic [DUR_W-1:0]      ld_dur_s;

    function automatic logic [PRESCALE_W-1:0] calc_period(input logic [3:0] t,
                                                          input logic [OCT_W-1:0] o);
        logic [PRESCALE_W-1:0] p;
        if (t < TONE_REST_MIN) begin
            p = PRESCALE_W'(TONE_TABLE[t]) >> o;
        end else begin
            p = PRESCALE_W'(1);
        end
        if (p == {PRESCALE_W{1'b0}}) begin
            p = PRESCALE_W'(1);
        end else begin
            p = p;
        end
        return p;
    endfunction

    // Next-state: expiry beats period counting; sustained notes hand over at a half-period boundary.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cnt_d        = cnt_q;
        dur_d        = dur_q;
        wave_d       = wave_q;
        done_d       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_tone_d  = pend_tone_q;
        pend_oct_d   = pend_oct_q;
        pend_dur_d   = pend_dur_q;
        load_s       = 1'b0;
        load_pend_s  = 1'b0;
        keep_wave_s  = 1'b0;

        accept_s   = note_valid && !pend_valid_q;
        active_s   = (state_q != IDLE);
        expire_s   = active_s && dur_tick && (dur_q == DUR_W'(1));
        boundary_s = (state_q == PLAY) && tick && (cnt_q == (period_q - PRESCALE_W'(1)));
        sustain_s  = active_s && (dur_q == {DUR_W{1'b0}});

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            PLAY, REST: begin
                if (expire_s) begin
                    done_d = 1'b1;
                    if (pend_valid_q) begin
                        load_s      = 1'b1;
                        load_pend_s = 1'b1;
                    end else if (accept_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        wave_d  = 1'b0;
                        cnt_d   = {PRESCALE_W{1'b0}};
                    end
                end else if (sustain_s && pend_valid_q && ((state_q == REST) || boundary_s)) begin
                    load_s      = 1'b1;
                    load_pend_s = 1'b1;
                    keep_wave_s = (state_q == PLAY);
                end else begin
                    if (dur_tick && !sustain_s) begin
                        dur_d = dur_q - DUR_W'(1);
                    end else begin
                        dur_d = dur_q;
                    end
                    if (boundary_s) begin
                        cnt_d  = {PRESCALE_W{1'b0}};
                        wave_d = !wave_q;
                    end else if ((state_q == PLAY) && tick) begin
                        cnt_d = cnt_q + PRESCALE_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (accept_s) begin
                        pend_valid_d = 1'b1;
                        pend_tone_d  = note_tone;
                        pend_oct_d   = note_octave;
                        pend_dur_d   = note_dur;
                    end else begin
                        pend_valid_d = pend_valid_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wave_d  = 1'b0;
            end
        endcase

        ld_tone_s = load_pend_s ? pend_tone_q : note_tone;
        ld_oct_s  = load_pend_s ? pend_oct_q  : note_octave;
        ld_dur_s  = load_pend_s ? pend_dur_q  : note_dur;

        if (load_s) begin
            state_d  = (ld_tone_s < TONE_REST_MIN) ? PLAY : REST;
            period_d = calc_period(ld_tone_s, ld_oct_s);
            cnt_d    = {PRESCALE_W{1'b0}};
            dur_d    = ld_dur_s;
            // A boundary handover keeps the edge it was due so the waveform stays continuous.
            wave_d   = (keep_wave_s && (ld_tone_s < TONE_REST_MIN)) ? !wave_q : 1'b0;
            if (load_pend_s) begin
                pend_valid_d = 1'b0;
            end else begin
                pend_valid_d = pend_valid_d;
            end
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != IDLE);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            period_q     <= {PRESCALE_W{1'b0}};
            cnt_q        <= {PRESCALE_W{1'b0}};
            dur_q        <= {DUR_W{1'b0}};
            wave_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_tone_q  <= 4'd0;
            pend_oct_q   <= {OCT_W{1'b0}};
            pend_dur_q   <= {DUR_W{1'b0}};
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            dur_q        <= dur_d;
            wave_q       <= wave_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pend_valid_q <= pend_valid_d;
            pend_tone_q  <= pend_tone_d;
            pend_oct_q   <= pend_oct_d;
            pend_dur_q   <= pend_dur_d;
        end
    end

    assign note_ready = !pend_valid_q;
    assign wave_out   = wave_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: rtl/tone_synth_mc.sv
// Multi-channel tone generator top: NUM_CH tone_channel instances plus the wave mixer.
// The mixer popcount is present only when TONE_SYNTH_MIX_EN is defined; otherwise mix_out is 0.
module tone_synth_mc
    import tone_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int PRESCALE_W = 10,
    parameter int OCT_W      = 2,
    parameter int DUR_W      = 8,
    localparam int MIX_W     = $clog2(NUM_CH + 1)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      tick,
    input  logic                      dur_tick,
    input  logic [NUM_CH-1:0]         note_valid,
    output logic [NUM_CH-1:0]         note_ready,
    input  logic [NUM_CH*4-1:0]       note_tone,
    input  logic [NUM_CH*OCT_W-1:0]   note_octave,
    input  logic [NUM_CH*DUR_W-1:0]   note_dur,
    output logic [NUM_CH-1:0]         wave_out,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [MIX_W-1:0]          mix_out
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tone_channel #(
            .PRESCALE_W (PRESCALE_W),
            .OCT_W      (OCT_W),
            .DUR_W      (DUR_W)
        ) u_ch (
            .clk         (clk),
            .resetN      (resetN),
            .tick        (tick),
            .dur_tick    (dur_tick),
            .note_valid  (note_valid[g]),
            .note_ready  (note_ready[g]),
            .note_tone   (note_tone[g*4 +: 4]),
            .note_octave (note_octave[g*OCT_W +: OCT_W]),
            .note_dur    (note_dur[g*DUR_W +: DUR_W]),
            .wave_out    (wave_out[g]),
            .busy        (busy[g]),
            .done        (done[g])
        );
    end

`ifdef TONE_SYNTH_MIX_EN
    logic [MIX_W-1:0] mix_q;

    // Registered count of channels currently driving high.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mix_q <= {MIX_W{1'b0}};
        end else begin
            mix_q <= MIX_W'(popcount32(32'(wave_out)));
        end
    end

    assign mix_out = mix_q;
`else
    assign mix_out = {MIX_W{1'b0}};
`endif

endmodule

// File: tb/tb_tone_synth_mc.sv
// Directed self-checking bench for tone_synth_mc (two channels, default widths).
module tb_tone_synth_mc;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        tick = 1'b0;
    logic        dur_tick = 1'b0;
    logic [1:0]  note_valid = 2'b00;
    logic [7:0]  note_tone = 8'h00;
    logic [3:0]  note_octave = 4'h0;
    logic [15:0] note_dur = 16'h0000;
    logic [1:0]  note_ready, wave_out, busy, done, mix_out;

    int compared = 0;
    int mismatched = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    tone_synth_mc dut (
        .clk         (clk),
        .resetN      (resetN),
        .tick        (tick),
        .dur_tick    (dur_tick),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_tone   (note_tone),
        .note_octave (note_octave),
        .note_dur    (note_dur),
        .wave_out    (wave_out),
        .busy        (busy),
        .done        (done),
        .mix_out     (mix_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done[0]) done_cnt0 <= done_cnt0 + 1;
        if (done[1]) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [3:0] t, input logic [1:0] o, input logic [7:0] d);
        note_valid[ch]         = 1'b1;
        note_tone[ch*4 +: 4]   = t;
        note_octave[ch*2 +: 2] = o;
        note_dur[ch*8 +: 8]    = d;
        step(1);
        note_valid[ch] = 1'b0;
    endtask

    task automatic dtick();
        step(9);
        dur_tick = 1'b1;
        step(1);
        dur_tick = 1'b0;
    endtask

    task automatic hard_reset();
        resetN = 1'b0;
        step(1);
        resetN = 1'b1;
        step(1);
    endtask

    initial begin
        step(2);
        chk("rst_wave",  32'(wave_out),   32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_done",  32'(done),       32'h0);
        chk("rst_ready", 32'(note_ready), 32'h3);
        chk("rst_mix",   32'(mix_out),    32'h0);
        resetN = 1'b1;
        step(1);

        // Both channels tone 9 octave 0 sustain, same start: half-period 0x1BB = 443.
        tick        = 1'b1;
        note_valid  = 2'b11;
        note_tone   = 8'h99;
        note_octave = 4'h0;
        note_dur    = 16'h0000;
        step(1);
        note_valid  = 2'b00;
        chk("load_busy",  32'(busy),       32'h3);
        chk("load_wave",  32'(wave_out),   32'h0);
        chk("load_ready", 32'(note_ready), 32'h3);
        step(442);
        chk("t442_wave", 32'(wave_out), 32'h0);
        step(1);
        chk("t443_wave", 32'(wave_out), 32'h3);
        chk("t443_mix",  32'(mix_out),  32'h0);
        step(1);
`ifdef TONE_SYNTH_MIX_EN
        chk("t444_mix", 32'(mix_out), 32'h2);
`else
        chk("t444_mix", 32'(mix_out), 32'h0);
`endif
        step(100);

        // Asynchronous reset in the middle of a high half-period.
        resetN = 1'b0;
        #1;
        chk("mid_rst_wave",  32'(wave_out),   32'h0);
        chk("mid_rst_busy",  32'(busy),       32'h0);
        chk("mid_rst_done",  32'(done),       32'h0);
        chk("mid_rst_ready", 32'(note_ready), 32'h3);
        chk("mid_rst_mix",   32'(mix_out),    32'h0);
        step(2);
        chk("mid_rst_nodone", 32'(done_cnt0 + done_cnt1), 32'h0);
        resetN = 1'b1;
        step(1);

        // Octave 2: 443 >> 2 = 110.
        send(0, 4'd9, 2'd2, 8'd0);
        step(109);
        chk("oct2_109", 32'(wave_out[0]), 32'h0);
        step(1);
        chk("oct2_110", 32'(wave_out[0]), 32'h1);
        step(109);
        chk("oct2_219", 32'(wave_out[0]), 32'h1);
        step(1);
        chk("oct2_220", 32'(wave_out[0]), 32'h0);
        hard_reset();

        // Sustain tone 9, then queue tone 11 (0x18B = 395) while the wave is high.
        send(0, 4'd9, 2'd0, 8'd0);
        step(443);
        chk("sus_first_tog", 32'(wave_out[0]),   32'h1);
        chk("sus_ready_pre", 32'(note_ready[0]), 32'h1);
        send(0, 4'd11, 2'd0, 8'd0);
        chk("sus_ready_q", 32'(note_ready[0]), 32'h0);
        step(441);
        chk("sus_pre_sw_wave",  32'(wave_out[0]),   32'h1);
        chk("sus_pre_sw_ready", 32'(note_ready[0]), 32'h0);
        step(1);
        chk("sus_sw_wave",  32'(wave_out[0]),   32'h0);
        chk("sus_sw_ready", 32'(note_ready[0]), 32'h1);
        chk("sus_sw_busy",  32'(busy[0]),       32'h1);
        step(394);
        chk("sus_new_394", 32'(wave_out[0]), 32'h0);
        step(1);
        chk("sus_new_395", 32'(wave_out[0]), 32'h1);
        chk("sus_nodone",  32'(done_cnt0),   32'h0);
        hard_reset();

        // Channel 1 rest of 3 duration ticks.
        send(1, 4'd13, 2'd0, 8'd3);
        chk("rest_busy", 32'(busy[1]),     32'h1);
        chk("rest_wave", 32'(wave_out[1]), 32'h0);
        dtick();
        chk("rest_d1_busy", 32'(busy[1]), 32'h1);
        chk("rest_d1_done", 32'(done[1]), 32'h0);
        dtick();
        chk("rest_d2_done", 32'(done[1]), 32'h0);
        dtick();
        chk("rest_d3_done", 32'(done[1]),     32'h1);
        chk("rest_d3_busy", 32'(busy[1]),     32'h0);
        chk("rest_d3_wave", 32'(wave_out[1]), 32'h0);
        step(1);
        chk("rest_done_1cyc", 32'(done[1]),   32'h0);
        chk("rest_done_cnt",  32'(done_cnt1), 32'h1);

        // Gapless queue: tone 0 dur 2, then tone 4 (0x250 = 592) dur 1.
        send(0, 4'd0, 2'd0, 8'd2);
        send(0, 4'd4, 2'd0, 8'd1);
        chk("q_ready", 32'(note_ready[0]), 32'h0);
        chk("q_busy",  32'(busy[0]),       32'h1);
        dtick();
        chk("q_d1_done",  32'(done[0]),       32'h0);
        chk("q_d1_ready", 32'(note_ready[0]), 32'h0);
        dtick();
        chk("q_d2_done",  32'(done[0]),       32'h1);
        chk("q_d2_busy",  32'(busy[0]),       32'h1);
        chk("q_d2_ready", 32'(note_ready[0]), 32'h1);
        step(591);
        chk("q_p591", 32'(wave_out[0]), 32'h0);
        step(1);
        chk("q_p592", 32'(wave_out[0]), 32'h1);
        dtick();
        chk("q_d3_done", 32'(done[0]),     32'h1);
        chk("q_d3_busy", 32'(busy[0]),     32'h0);
        chk("q_d3_wave", 32'(wave_out[0]), 32'h0);
        step(1);
        chk("q_done_cnt", 32'(done_cnt0), 32'h2);

        // Accept in the same cycle as expiry with the slot empty.
        send(1, 4'd13, 2'd0, 8'd1);
        step(9);
        dur_tick      = 1'b1;
        note_valid[1] = 1'b1;
        note_tone[7:4] = 4'd14;
        note_dur[15:8] = 8'd1;
        step(1);
        dur_tick      = 1'b0;
        note_valid[1] = 1'b0;
        chk("acc_exp_done", 32'(done[1]), 32'h1);
        chk("acc_exp_busy", 32'(busy[1]), 32'h1);
        dtick();
        chk("acc_exp2_done", 32'(done[1]), 32'h1);
        chk("acc_exp2_busy", 32'(busy[1]), 32'h0);
        step(1);
        chk("acc_done_cnt", 32'(done_cnt1), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
